// File: rtl/mips_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_pkg: shared encodings for the EX-stage multiply/divide unit. Rev 1.0
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_muldiv_unit_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_step: one combinational iteration, shift-add or restoring divide. Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // The remainder after a successful subtract is below the divisor, so the
    // low WIDTH bits of the difference are exact.
    always_comb begin
        sum      = {1'b0, acc_hi_i} + {1'b0, (acc_lo_i[0] ? operand_i : {WIDTH{1'b0}})};
        shifted  = {acc_hi_i, acc_lo_i[WIDTH-1]};
        fits     = (shifted >= {1'b0, operand_i});
        diff     = shifted[WIDTH-1:0] - operand_i;
        acc_hi_o = sum[WIDTH:1];
        acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
        if (is_div_i) begin
            acc_hi_o = fits ? diff : shifted[WIDTH-1:0];
            acc_lo_o = {acc_lo_i[WIDTH-2:0], fits};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Rev 1.0
// ---------------------------------------------------------------------------
module mips_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_t        state_q;
    logic [CNT_W-1:0] count_q;
    logic             is_div_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic             neg_a_d;
    logic             neg_b_d;
    logic [WIDTH-1:0] mag_a_d;
    logic [WIDTH-1:0] mag_b_d;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        neg_a_d = md_is_signed(op) & a[WIDTH-1];
        neg_b_d = md_is_signed(op) & b[WIDTH-1];
        mag_a_d = neg_a_d ? -a : a;
        mag_b_d = neg_b_d ? -b : b;
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div_i  (is_div_q),
        .acc_hi_i  (acc_hi_q),
        .acc_lo_i  (acc_lo_q),
        .operand_i (opnd_q),
        .acc_hi_o  (step_hi),
        .acc_lo_o  (step_lo)
    );

    // A zero divisor leaves the dividend magnitude in the remainder, so the
    // remainder sign fix already yields hi = a; only lo needs overriding.
    // Most-negative / -1 falls out of the magnitude path without a special case.
    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        quot_fix = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
        rem_fix  = neg_a_q ? -acc_hi_q : acc_hi_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            is_div_q   <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
            opnd_q     <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !cancel) begin
                        state_q    <= CALC;
                        count_q    <= '0;
                        is_div_q   <= md_is_div(op);
                        neg_a_q    <= neg_a_d;
                        neg_b_q    <= neg_b_d;
                        div_zero_q <= md_is_div(op) && (b == '0);
                        acc_hi_q   <= '0;
                        acc_lo_q   <= md_is_div(op) ? mag_a_d : mag_b_d;
                        opnd_q     <= md_is_div(op) ? mag_b_d : mag_a_d;
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state_q <= IDLE;
                    end else begin
                        acc_hi_q <= step_hi;
                        acc_lo_q <= step_lo;
                        count_q  <= count_q + 1'b1;
                        if (count_q == LAST_ITER) state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    if (!cancel) begin
                        done_q <= 1'b1;
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= div_zero_q ? {WIDTH{1'b1}} : quot_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire
